// File: rtl/serial_framer_pkg.sv
// Shared types and line-level constants for the serial framer.
package serial_framer_pkg;

  // Frame sequencer states. The S_ prefix keeps the GAP state distinct from
  // the framer's GAP parameter.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  // Line level driven during the start bit.
  localparam logic START_LEVEL = 1'b1;

  // Line level driven whenever no frame bit is on the wire.
  localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/serial_framer.sv
// Parallel-to-serial framer: one-word hold buffer, MSB-first shifter and a
// frame sequencer producing start / data / optional even parity bits.
// Every output comes straight from a flop, so the line bits lag the state
// register by one cycle.
module serial_framer
  import serial_framer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = $clog2(GAP + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

  state_t             state_q, state_nxt;
  logic [WIDTH-1:0]   hold_q, hold_nxt;
  logic               hold_full_q, hold_full_nxt;
  logic [WIDTH-1:0]   shift_q, shift_nxt;
  logic               parity_q, parity_nxt;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_nxt;
  logic               sout_nxt;
  logic               sout_valid_nxt;
  logic               frame_done_nxt;
  logic               busy_nxt;
  logic               load;
  logic               accept;

  // Next-state, datapath and next-output logic for the frame sequencer.
  // The load from hold is applied before the accept so that an accept in
  // the same cycle refills the buffer rather than being cleared by the load.
  always_comb begin
    state_nxt      = state_q;
    hold_nxt       = hold_q;
    hold_full_nxt  = hold_full_q;
    shift_nxt      = shift_q;
    parity_nxt     = parity_q;
    bit_cnt_nxt    = bit_cnt_q;
    gap_cnt_nxt    = gap_cnt_q;
    sout_nxt       = IDLE_LEVEL;
    sout_valid_nxt = 1'b0;
    frame_done_nxt = 1'b0;
    load           = 1'b0;
    accept         = in_valid && in_ready;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end

      S_START: begin
        sout_nxt       = START_LEVEL;
        sout_valid_nxt = 1'b1;
        bit_cnt_nxt    = '0;
        state_nxt      = S_DATA;
      end

      S_DATA: begin
        sout_nxt       = shift_q[WIDTH-1];
        sout_valid_nxt = 1'b1;
        shift_nxt      = {shift_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          gap_cnt_nxt = '0;
          if (PARITY_EN) begin
            state_nxt = S_PARITY;
          end else begin
            frame_done_nxt = 1'b1;
            state_nxt      = S_GAP;
          end
        end else begin
          bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        sout_nxt       = parity_q;
        sout_valid_nxt = 1'b1;
        frame_done_nxt = 1'b1;
        gap_cnt_nxt    = '0;
        state_nxt      = S_GAP;
      end

      S_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (load) begin
      shift_nxt     = hold_q;
      parity_nxt    = ^hold_q;
      hold_full_nxt = 1'b0;
      state_nxt     = S_START;
    end

    if (accept) begin
      hold_nxt      = in_data;
      hold_full_nxt = 1'b1;
    end

    busy_nxt = (state_nxt != S_IDLE) || hold_full_nxt;
  end

  // State, datapath and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sout        <= IDLE_LEVEL;
      sout_valid  <= 1'b0;
      frame_done  <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      hold_q      <= hold_nxt;
      hold_full_q <= hold_full_nxt;
      shift_q     <= shift_nxt;
      parity_q    <= parity_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      gap_cnt_q   <= gap_cnt_nxt;
      sout        <= sout_nxt;
      sout_valid  <= sout_valid_nxt;
      frame_done  <= frame_done_nxt;
      in_ready    <= !hold_full_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_serial_framer.sv
// Directed bench for serial_framer: one instance with parity, one without,
// a frame decoder on the parity instance and a 4-bit SIPO on the other.
module tb_serial_framer;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] in_data0;
  logic       in_valid0;
  logic       in_ready0, sout0, sout_valid0, frame_done0, busy0;

  logic [3:0] in_data1;
  logic       in_valid1;
  logic       in_ready1, sout1, sout_valid1, frame_done1, busy1;

  int checks = 0;
  int errors = 0;

  logic [5:0] mon_bits = '0;
  logic [3:0] rx_words[$];
  int         rx_bad = 0;
  logic [3:0] sipo = '0;

  always #5 clk = ~clk;

  serial_framer #(.WIDTH(4), .PARITY_EN(1'b1), .GAP(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .sout(sout0), .sout_valid(sout_valid0),
    .frame_done(frame_done0), .busy(busy0)
  );

  serial_framer #(.WIDTH(4), .PARITY_EN(1'b0), .GAP(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .frame_done(frame_done1), .busy(busy1)
  );

  // Decode frames from the parity instance: start bit, 4 data bits, parity.
  always @(negedge clk) begin
    if (!reset) begin
      mon_bits <= '0;
    end else if (sout_valid0) begin
      if (frame_done0) begin
        rx_words.push_back(mon_bits[3:0]);
        if (mon_bits[4] !== 1'b1 || (^{mon_bits[3:0], sout0}) !== 1'b0)
          rx_bad <= rx_bad + 1;
        mon_bits <= '0;
      end else begin
        mon_bits <= {mon_bits[4:0], sout0};
      end
    end
  end

  // Downstream 4-bit serial-in/parallel-out register fed by the no-parity instance.
  always @(posedge clk) begin
    sipo <= {sipo[2:0], sout1};
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] data);
    in_valid0 = valid;
    in_data0  = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0]  exp_single;
    logic [13:0] exp_b2b;
    logic [3:0]  bp_words [3];
    logic [3:0]  np_words [2];
    logic [4:0]  np_frame;
    logic [3:0]  got;
    logic        accepted, was_ready;
    int          stray;

    reset = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0;
    in_valid1 = 1'b0; in_data1 = '0;

    // Reset held across edges.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst sout", sout0, 0);
    check_output("rst sout_valid", sout_valid0, 0);
    check_output("rst frame_done", frame_done0, 0);
    check_output("rst in_ready", in_ready0, 1);
    check_output("rst busy", busy0, 0);
    check_output("rst in_ready np", in_ready1, 1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("idle sout", sout0, 0);
    end

    // Single frame 1011: start,1,0,1,1,parity 1 on edges 2..7.
    $display("[TB] single frame");
    exp_single = 6'b110111;
    apply_stimulus(1'b1, 4'b1011);
    step();
    apply_stimulus(1'b0, 4'b0000);
    check_output("hold full ready", in_ready0, 0);
    check_output("hold full busy", busy0, 1);
    step();
    check_output("latency sout", sout0, 0);
    check_output("ready after load", in_ready0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_output("single sout", sout0, exp_single[5-i]);
      check_output("single valid", sout_valid0, 1);
      check_output("single done", frame_done0, (i == 5));
    end
    step();
    check_output("post sout", sout0, 0);
    check_output("post valid", sout_valid0, 0);
    check_output("post done", frame_done0, 0);
    check_output("post busy", busy0, 0);
    repeat (2) step();

    // Back-to-back 1011 then 0110; edges 2..15.
    $display("[TB] back-to-back");
    exp_b2b = 14'b1101110_1011000;
    apply_stimulus(1'b1, 4'b1011);
    step();
    apply_stimulus(1'b0, 4'b0000);
    step();
    apply_stimulus(1'b1, 4'b0110);
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 0) begin
        apply_stimulus(1'b0, 4'b0000);
        check_output("b2b second held", in_ready0, 0);
      end
      check_output("b2b sout", sout0, exp_b2b[13-k]);
      check_output("b2b done", frame_done0, (k == 5 || k == 12));
    end
    check_output("b2b busy end", busy0, 0);
    repeat (3) step();

    // Backpressure: valid held high across three queued words.
    $display("[TB] backpressure");
    rx_words.delete();
    bp_words[0] = 4'b0011; bp_words[1] = 4'b1100; bp_words[2] = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, bp_words[i]);
      accepted = 1'b0;
      for (int t = 0; t < 40 && !accepted; t++) begin
        was_ready = in_ready0;
        step();
        if (was_ready) accepted = 1'b1;
      end
      check_output("bp accept", accepted, 1);
      check_output("bp ready low", in_ready0, 0);
    end
    apply_stimulus(1'b0, 4'b0000);
    repeat (30) step();
    check_output("bp count", rx_words.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (rx_words.size() > i) ? rx_words[i] : 4'bxxxx;
      check_output("bp word", got, bp_words[i]);
    end
    check_output("bp framing", rx_bad, 0);

    // Reset during DATA with a second word waiting in hold.
    $display("[TB] reset mid-frame");
    rx_words.delete();
    apply_stimulus(1'b1, 4'b1011);
    step();
    apply_stimulus(1'b0, 4'b0000);
    step();
    apply_stimulus(1'b1, 4'b0110);
    step();
    apply_stimulus(1'b0, 4'b0000);
    step();
    check_output("pre-rst sout", sout0, 1);
    check_output("pre-rst valid", sout_valid0, 1);
    reset = 1'b0;
    #2;
    check_output("async sout", sout0, 0);
    check_output("async valid", sout_valid0, 0);
    check_output("async ready", in_ready0, 1);
    check_output("async busy", busy0, 0);
    step();
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sout0 || sout_valid0 || busy0) stray++;
    end
    check_output("no remnant", stray, 0);
    check_output("no remnant rx", rx_words.size(), 0);

    // No-parity instance: 5-bit frames, captured by the SIPO.
    $display("[TB] no parity");
    np_words[0] = 4'b1111; np_words[1] = 4'b1001;
    for (int w = 0; w < 2; w++) begin
      np_frame = {1'b1, np_words[w]};
      in_valid1 = 1'b1; in_data1 = np_words[w];
      step();
      in_valid1 = 1'b0; in_data1 = '0;
      step();
      for (int i = 0; i < 5; i++) begin
        step();
        check_output("np sout", sout1, np_frame[4-i]);
        check_output("np done", frame_done1, (i == 4));
      end
      step();
      check_output("np valid off", sout_valid1, 0);
      check_output("np sipo", sipo, np_words[w]);
      repeat (2) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
